// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider with round-robin divide-change arbitration.
package clkdiv_pkg;

    localparam int DIV_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/clkdiv_if.sv
// Requester-facing bundle: divide-change requests and grants, plus the divided-clock status outputs.
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DIV_W = DIV_W_DEF
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*DIV_W-1:0] div_val;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   clk_out;
    logic                   tick;
    logic [DIV_W-1:0]       cur_div;

    modport master (
        output req, div_val,
        input  grant, busy, clk_out, tick, cur_div
    );

    modport slave (
        input  req, div_val,
        output grant, busy, clk_out, tick, cur_div
    );

endinterface

// File: rtl/clkdiv_core.sv
// Programmable divider: counts 0..div, flips clk_out on the terminal count.
// at_fall flags the terminal count of a high phase, the only safe point to change div.
module clkdiv_core
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             at_fall
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap    = (cnt == div);
    assign at_fall = wrap && clk_out;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (load) begin
            // load only coincides with a falling toggle, so this is still a tick
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b1;
        end else begin
            cnt     <= wrap ? '0 : cnt + 1'b1;
            clk_out <= clk_out ^ wrap;
            tick    <= wrap;
        end
    end

endmodule

// File: rtl/clkdiv_arbiter.sv
// Round-robin arbitration of divide-change requests; granted values are applied at the next falling toggle.
//   state   | meaning
//   IDLE    | no change outstanding, arbitrating req each cycle
//   PENDING | granted value held, waiting for the falling toggle to switch
module clkdiv_arbiter
    import clkdiv_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic     clk_in,
    input  logic     rst_n,
    clkdiv_if.slave  bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                        state, state_nxt;
    logic [PTR_W-1:0]              rr_ptr, rr_ptr_nxt;
    logic [N_REQ-1:0]              grant_q, grant_nxt;
    logic [DIV_W-1:0]              pend_q, pend_nxt;
    logic [DIV_W-1:0]              cur_div_q, cur_div_nxt;
    logic [N_REQ-1:0][DIV_W-1:0]   dv_arr;
    logic [PTR_W-1:0]              idx, win;
    logic                          found;
    logic                          load;
    logic                          at_fall;
    logic                          core_clk;
    logic                          core_tick;

    assign dv_arr = bus.div_val;

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        grant_nxt   = '0;
        pend_nxt    = pend_q;
        cur_div_nxt = cur_div_q;
        load        = 1'b0;
        found       = 1'b0;
        idx         = '0;
        win         = '0;
        case (state)
            IDLE: begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    grant_nxt[win] = 1'b1;
                    pend_nxt       = dv_arr[win];
                    rr_ptr_nxt     = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    state_nxt      = PENDING;
                end
            end
            PENDING: begin
                if (at_fall) begin
                    cur_div_nxt = pend_q;
                    load        = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            pend_q    <= '0;
            cur_div_q <= DIV_W'(DEFAULT_DIV);
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_q   <= grant_nxt;
            pend_q    <= pend_nxt;
            cur_div_q <= cur_div_nxt;
        end
    end

    clkdiv_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .div     (cur_div_q),
        .load    (load),
        .clk_out (core_clk),
        .tick    (core_tick),
        .at_fall (at_fall)
    );

    assign bus.grant   = grant_q;
    assign bus.busy    = (state == PENDING);
    assign bus.clk_out = core_clk;
    assign bus.tick    = core_tick;
    assign bus.cur_div = cur_div_q;

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// Bench for clkdiv_arbiter: phase-length reference model feeding a grant scoreboard, plus per-cycle waveform checks.
module tb_clkdiv_arbiter;
    import clkdiv_pkg::*;

    localparam int N   = 4;
    localparam int W   = DIV_W_DEF;
    localparam int DEF = DEFAULT_DIV_DEF;

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic [N-1:0]   req_r  = '0;
    logic [N*W-1:0] dv_r   = '0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    clkdiv_if #(.N_REQ(N), .DIV_W(W)) bus ();

    assign bus.req     = req_r;
    assign bus.div_val = dv_r;

    clkdiv_arbiter #(.N_REQ(N), .DIV_W(W), .DEFAULT_DIV(DEF)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each clk_out phase lasts div+1 cycles; a granted value
    // takes effect at the end of a high phase; the grant shows the cycle after arbitration.
    typedef struct { int cyc; int idx; } gexp_t;
    gexp_t gq[$];
    int cyc = 0;
    bit m_lvl, m_tick, m_pend, m_was, m_found;
    int m_left, m_div, m_pval, m_ptr, m_i;

    always @(posedge clk_in) begin
        cyc++;
        if (!rst_n) begin
            m_lvl  = 0;
            m_div  = DEF;
            m_left = DEF + 1;
            m_tick = 0;
            m_pend = 0;
            m_ptr  = 0;
        end else begin
            m_was = m_pend;
            if (m_left == 1) begin
                if (m_lvl && m_was) begin
                    m_div  = m_pval;
                    m_pend = 0;
                end
                m_lvl  = !m_lvl;
                m_tick = 1;
                m_left = m_div + 1;
            end else begin
                m_left--;
                m_tick = 0;
            end
            if (!m_was && req_r != '0) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    m_i = (m_ptr + k) % N;
                    if (!m_found && req_r[m_i]) begin
                        m_found = 1;
                        gq.push_back('{cyc, m_i});
                        m_pval = int'(dv_r[m_i*W +: W]);
                        m_pend = 1;
                        m_ptr  = (m_i + 1) % N;
                    end
                end
            end
        end
    end

    gexp_t g;
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("clk_out", int'(bus.clk_out), int'(m_lvl));
            chk("tick", int'(bus.tick), int'(m_tick));
            chk("busy", int'(bus.busy), int'(m_pend));
            chk("cur_div", int'(bus.cur_div), m_div);
            if (bus.grant != '0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexp", int'(bus.grant), 0);
                end else begin
                    g = gq.pop_front();
                    chk("grant", int'(bus.grant), 1 << g.idx);
                    chk("grant_cyc", cyc, g.cyc);
                end
            end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                chk("grant_missed", int'(bus.grant), 1 << gq[0].idx);
                void'(gq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        req_r = req_r & ~bus.grant;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int v);
        dv_r[i*W +: W] = W'(v);
        req_r[i] = 1'b1;
    endtask

    task automatic wait_grant(input int i, input int max_cyc);
        bit seen;
        seen = 0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            step();
            if (bus.grant[i]) seen = 1;
        end
        chk($sformatf("wait_grant%0d", i), int'(seen), 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle;
        idle = 0;
        for (int c = 0; c < max_cyc && !idle; c++) begin
            step();
            if (!bus.busy) idle = 1;
        end
        chk("wait_idle", int'(idle), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        chk_en = 1;
        rst_n  = 1'b1;
        chk("reset_cur_div", int'(bus.cur_div), DEF);
        chk("reset_clk_out", int'(bus.clk_out), 0);
        repeat (30) step();

        // single request, divide 2
        set_req(1, 2);
        wait_grant(1, 4);
        wait_idle(20);
        chk("single_cur_div", int'(bus.cur_div), 2);
        repeat (24) step();

        // simultaneous requests after reset: 0 wins, 2 follows
        do_reset();
        set_req(0, 3);
        set_req(2, 1);
        wait_grant(0, 4);
        wait_grant(2, 30);
        wait_idle(30);
        chk("simul_cur_div", int'(bus.cur_div), 1);
        repeat (12) step();

        // divide zero
        set_req(3, 0);
        wait_grant(3, 4);
        wait_idle(30);
        repeat (16) step();
        chk("div0_tick", int'(bus.tick), 1);

        // reset while a change to 9 is pending
        do_reset();
        set_req(1, 9);
        wait_grant(1, 4);
        repeat (2) step();
        chk("abort_busy_before", int'(bus.busy), 1);
        do_reset();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cur_div", int'(bus.cur_div), DEF);
        chk("abort_clk_out", int'(bus.clk_out), 0);
        repeat (40) step();
        chk("abort_cur_div_later", int'(bus.cur_div), DEF);

        // request rising while busy
        set_req(0, 4);
        wait_grant(0, 4);
        repeat (2) step();
        set_req(3, 1);
        wait_grant(3, 40);
        wait_idle(30);
        repeat (10) step();

        // randomized request traffic
        repeat (500) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_r[i] && $urandom_range(0, 5) == 0)
                    set_req(i, int'($urandom_range(0, 6)));
            end
        end
        for (int c = 0; c < 400 && (req_r != '0 || bus.busy); c++) step();
        chk("drain_req", int'(req_r), 0);
        chk("drain_busy", int'(bus.busy), 0);
        repeat (2) step();
        chk("queue_empty", gq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_arbiter.md
CLKDIV_ARBITER -- requirements
Module: clkdiv_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 The block SHALL have parameter DIV_W, default 8: divide-value width.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 5: divide value loaded at reset.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester divide-change request, level, held until granted.
REQ-007 The block SHALL have port div_val, input, N_REQ*DIV_W bits: requested divide value; slice i belongs to req[i].
REQ-008 The block SHALL have port grant, output, N_REQ bits: one-hot, one-cycle grant pulse.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a granted change is pending.
REQ-010 The block SHALL have port clk_out, output, 1 bit: divided clock.
REQ-011 The block SHALL have port cur_div, output, DIV_W bits: divide value in effect.
REQ-012 The block SHALL have port tick, output, 1 bit: one-cycle pulse in every cycle in which clk_out toggles.

Function
REQ-013 The divider counter SHALL count 0..cur_div, then wrap to 0; clk_out SHALL invert on the cycle the counter equals cur_div, so that half-period = cur_div+1 clk_in cycles.
REQ-014 When cur_div=0, clk_out SHALL toggle every cycle and tick SHALL stay high.
REQ-015 Unsigned arithmetic only; the counter SHALL be DIV_W bits and never exceed cur_div.
REQ-016 The FSM SHALL have two states: IDLE and PENDING.
REQ-017 In IDLE with any req bit high, the winner SHALL be chosen round-robin: highest priority is the index after the last grant (index 0 after reset).
REQ-018 On that edge, grant[winner] SHALL assert for exactly one cycle, the winner's div_val slice SHALL be latched into a pending register, and the state SHALL go to PENDING.
REQ-019 In PENDING, req SHALL be ignored, no grant SHALL issue, and busy SHALL be 1.
REQ-020 The switch point SHALL be the cycle in which the counter equals cur_div while clk_out=1, i.e. the falling toggle.
REQ-021 At the switch point, clk_out SHALL go to 0, cur_div SHALL load the pending value, the counter SHALL go to 0, and the state SHALL return to IDLE.
REQ-022 No clk_out high or low phase SHALL be shorter than min(old, new)+1 cycles (glitch-free switch).
REQ-023 A grant to a requester whose value equals cur_div SHALL still go through PENDING; waveform is unchanged.
REQ-024 Requests still high in the first IDLE cycle after a switch SHALL be arbitrated in that cycle.
REQ-025 busy SHALL be 0 exactly when the state is IDLE.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set clk_out=0, counter=0, cur_div=DEFAULT_DIV, grant=0, busy=0, tick=0, state=IDLE and round-robin pointer=0, and SHALL discard the pending value.
REQ-027 Reset asserted mid-PENDING SHALL abort the change; the aborted requester is not re-granted unless it re-requests.

Structure
REQ-028 Package clkdiv_pkg SHALL hold the FSM state enum and the default DIV_W/DEFAULT_DIV constants.
REQ-029 The block SHALL instantiate one sub-module, clkdiv_core, as the programmable counter with ports clk_in, rst_n, div, load, clk_out, tick, at_fall; arbitration and FSM SHALL stay in clkdiv_arbiter.

Verification
REQ-030 The bench SHALL cover post-reset operation: release rst_n with no req -> clk_out low, cur_div=5, toggles every 6 cycles (period 12).
REQ-031 The bench SHALL cover a single request: req[1]=1 with div_val[1]=2 -> grant[1] pulses the next cycle, busy high until the next falling toggle, then period 6, cur_div=2.
REQ-032 The bench SHALL cover simultaneous requests after reset: req[0] and req[2] together -> grant[0] first; grant[2] in the first IDLE cycle after req[0]'s switch; final cur_div=div_val[2].
REQ-033 The bench SHALL cover divide value zero: a grant with div_val=0 -> after the switch, clk_out toggles every cycle and tick is constantly 1.
REQ-034 The bench SHALL cover reset mid-operation: assert rst_n=0 while PENDING with pending value 9 -> cur_div=5, busy=0, clk_out=0; the value 9 is never applied.
REQ-035 The bench SHALL cover requests while busy: req[3] rises during PENDING -> no grant until IDLE; grant[3] in the first IDLE cycle.
